// File: rtl/regfile_wb_sched_if.sv
// Bundle of the writeback scheduler's buses, so that the scheduler and its
// neighbours connect through one port.
//   issue      : iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen, iss_long -> iss_stall
//   ALU wb     : alu_we, alu_wa, alu_wd -> alu_hold
//   long unit  : lu_valid, lu_wa, lu_wd -> lu_ready
//   regfile    : rf_we, rf_wa, rf_wd (driven by the scheduler)
// The slave modport is the scheduler's view. The master modport is the view
// of the surrounding pipeline.
interface regfile_wb_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  iss_valid;
    logic [RD_WIDTH-1:0]   iss_rs1;
    logic [RD_WIDTH-1:0]   iss_rs2;
    logic [RD_WIDTH-1:0]   iss_rd;
    logic                  iss_wen;
    logic                  iss_long;
    logic                  iss_stall;

    logic                  alu_we;
    logic [RD_WIDTH-1:0]   alu_wa;
    logic [DATA_WIDTH-1:0] alu_wd;
    logic                  alu_hold;

    logic                  lu_valid;
    logic [RD_WIDTH-1:0]   lu_wa;
    logic [DATA_WIDTH-1:0] lu_wd;
    logic                  lu_ready;

    logic                  rf_we;
    logic [RD_WIDTH-1:0]   rf_wa;
    logic [DATA_WIDTH-1:0] rf_wd;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen, iss_long,
        output iss_stall,
        input  alu_we, alu_wa, alu_wd,
        output alu_hold,
        input  lu_valid, lu_wa, lu_wd,
        output lu_ready,
        output rf_we, rf_wa, rf_wd
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen, iss_long,
        input  iss_stall,
        output alu_we, alu_wa, alu_wd,
        input  alu_hold,
        output lu_valid, lu_wa, lu_wd,
        input  lu_ready,
        input  rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard for the register file's single write
// port. It merges the single-cycle ALU writeback stream with the writeback
// stream from the long-latency unit, and produces one registered write. The
// long-unit results pass through a 2-entry in-order FIFO. The ALU has
// priority. A starvation guard holds the ALU for one cycle, so that a full
// FIFO cannot wait forever. Registers that have a long write outstanding are
// tracked in a pending vector. Issue stalls on RAW and WAW hazards against
// those registers, and also when the count of outstanding long writes is at
// its limit.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : regfile_wb_sched_if.slave (issue, ALU wb, long-unit wb, rf write)
module regfile_wb_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_sched_if.slave     bus
);
    localparam int NREG = 1 << RD_WIDTH;
    localparam int CW   = $clog2(MAX_OUT + 1);
    localparam int SW   = $clog2(STARVE_LIM + 1);
    // x0 is hardwired, so its pending bit is masked off on every update.
    localparam logic [NREG-1:0] NO_X0 = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0]       pending;
    logic [CW-1:0]         cnt;
    logic [RD_WIDTH-1:0]   fifo_wa [2];
    logic [DATA_WIDTH-1:0] fifo_wd [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fcnt;
    logic [SW-1:0]         starve;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  alu_sel;
    logic [RD_WIDTH-1:0]   head_wa;
    logic [DATA_WIDTH-1:0] head_wd;
    logic                  set_en;
    logic                  dec_en;
    logic                  stall;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;

    assign fifo_full  = (fcnt == 2'd2);
    assign fifo_empty = (fcnt == 2'd0);
    assign head_wa    = fifo_wa[rd_ptr];
    assign head_wd    = fifo_wd[rd_ptr];

    // lu_ready uses the current occupancy only. A pop in this cycle does not
    // free a slot for a push in the same cycle.
    assign bus.lu_ready = !fifo_full;
    assign push         = bus.lu_valid && !fifo_full;

    // The ALU wins the write port unless it is held. A pop needs an entry that
    // is already stored in the FIFO.
    assign alu_sel = bus.alu_we && !bus.alu_hold;
    assign pop     = !alu_sel && !fifo_empty;

    assign stall = bus.iss_valid &&
                   (pending[bus.iss_rs1] || pending[bus.iss_rs2] ||
                    (bus.iss_wen && pending[bus.iss_rd]) ||
                    (bus.iss_long && (cnt == CW'(MAX_OUT))));
    assign bus.iss_stall = stall;

    assign set_en = bus.iss_valid && !stall && bus.iss_long &&
                    bus.iss_wen && (bus.iss_rd != '0);
    // An x0 long entry never counted as outstanding, so popping it leaves cnt as it is.
    assign dec_en = pop && (head_wa != '0) && (cnt != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[bus.iss_rd] = set_en;
        clr_mask[head_wa]    = pop;
    end

    // Scoreboard. A set and a clear of the same bit cannot happen together,
    // because the WAW check blocks that issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & NO_X0;
            case ({set_en, dec_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fcnt   <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // FIFO storage. It holds only data, and fcnt says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= bus.lu_wa;
            fifo_wd[wr_ptr] <= bus.lu_wd;
        end
    end

    // Starvation guard. starve counts the cycles in which the FIFO is full and
    // nothing pops. When the count of such cycles reaches STARVE_LIM, alu_hold
    // is raised for one cycle, and that cycle pops the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve       <= '0;
            bus.alu_hold <= 1'b0;
        end else begin
            if (pop)
                starve <= '0;
            else if (fifo_full && (starve != SW'(STARVE_LIM)))
                starve <= starve + SW'(1);
            bus.alu_hold <= fifo_full && !pop && !bus.alu_hold &&
                            (starve == SW'(STARVE_LIM - 1));
        end
    end

    // Commit stage: the write port register. Writes to x0 are dropped, but
    // the x0 entry still pops from the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_wa <= '0;
            bus.rf_wd <= '0;
        end else if (alu_sel) begin
            bus.rf_we <= (bus.alu_wa != '0);
            bus.rf_wa <= bus.alu_wa;
            bus.rf_wd <= bus.alu_wd;
        end else if (pop) begin
            bus.rf_we <= (head_wa != '0);
            bus.rf_wa <= head_wa;
            bus.rf_wd <= head_wd;
        end else begin
            bus.rf_we <= 1'b0;
        end
    end
endmodule
